// File: rtl/uart_rx_fifo.sv
// 8N1 UART receiver: 2-flop synchroniser, mid-bit sampling FSM, receive queue.
// Define UART_RX_FIFO_EN for a 2^AW-deep FIFO; otherwise a single holding register.
module uart_rx_fifo #(
    parameter int DIVW = 16,
    parameter int AW   = 4
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            rxd,
    input  logic [DIVW-1:0] divider,
    input  logic            rd,
    input  logic            clr,
    output logic [7:0]      dout,
    output logic            dv,
    output logic            ferr,
    output logic            ovf,
    output logic            busy
);
    typedef enum logic [2:0] {
        S_IDLE, S_START, S_DATA, S_STOP, S_BRK
    } state_t;

    state_t          state_q, state_d;
    logic            rx1_q, rx_s_q;
    logic [DIVW-1:0] bcnt_q, bcnt_d;
    logic [2:0]      bidx_q, bidx_d;
    logic [7:0]      sh_q, sh_d;
    logic            ferr_q, ovf_q;
    logic            push, ferr_set, full, do_pop, do_push;
    logic            bzero;

    assign bzero = (bcnt_q == '0);
    assign busy  = (state_q != S_IDLE);

    always_ff @(posedge clk) begin
        if (reset) begin
            rx1_q   <= 1'b1;
            rx_s_q  <= 1'b1;
            state_q <= S_IDLE;
            bcnt_q  <= '0;
            bidx_q  <= '0;
            sh_q    <= '0;
        end else begin
            rx1_q   <= rxd;
            rx_s_q  <= rx1_q;
            state_q <= state_d;
            bcnt_q  <= bcnt_d;
            bidx_q  <= bidx_d;
            sh_q    <= sh_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        bcnt_d   = bcnt_q;
        bidx_d   = bidx_q;
        sh_d     = sh_q;
        push     = 1'b0;
        ferr_set = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (!rx_s_q) begin
                    bcnt_d  = divider >> 1;
                    state_d = S_START;
                end
            end
            S_START: begin
                if (!bzero) begin
                    bcnt_d = bcnt_q - DIVW'(1);
                end else if (rx_s_q) begin
                    state_d = S_IDLE;
                end else begin
                    bcnt_d  = divider - DIVW'(1);
                    bidx_d  = 3'd0;
                    state_d = S_DATA;
                end
            end
            S_DATA: begin
                if (!bzero) begin
                    bcnt_d = bcnt_q - DIVW'(1);
                end else begin
                    sh_d   = {rx_s_q, sh_q[7:1]};
                    bcnt_d = divider - DIVW'(1);
                    bidx_d = bidx_q + 3'd1;
                    if (bidx_q == 3'd7) state_d = S_STOP;
                end
            end
            S_STOP: begin
                if (!bzero) begin
                    bcnt_d = bcnt_q - DIVW'(1);
                end else if (rx_s_q) begin
                    push    = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    ferr_set = 1'b1;
                    state_d  = S_BRK;
                end
            end
            S_BRK: begin
                if (rx_s_q) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // A pop in the same cycle frees the slot the push needs.
    assign do_pop  = rd && dv;
    assign do_push = push && (!full || do_pop);

`ifdef UART_RX_FIFO_EN
    localparam int DEPTH = 1 << AW;
    logic [7:0]  mem_q [DEPTH];
    logic [AW-1:0] wptr_q, rptr_q;
    logic [AW:0]   cnt_q;

    assign full = (cnt_q == (AW+1)'(DEPTH));
    assign dv   = (cnt_q != '0);
    assign dout = dv ? mem_q[rptr_q] : 8'h00;

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wptr_q] <= sh_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
        end else begin
            if (do_push) wptr_q <= wptr_q + AW'(1);
            if (do_pop)  rptr_q <= rptr_q + AW'(1);
            if (do_push && !do_pop)      cnt_q <= cnt_q + (AW+1)'(1);
            else if (do_pop && !do_push) cnt_q <= cnt_q - (AW+1)'(1);
        end
    end
`else
    logic [7:0]  hold_q;
    logic        full_q;
    logic [AW:0] unused_aw;

    assign unused_aw = '0;
    assign full = full_q;
    assign dv   = full_q;
    assign dout = full_q ? hold_q : 8'h00;

    always_ff @(posedge clk) begin
        if (reset) begin
            hold_q <= '0;
            full_q <= 1'b0;
        end else if (do_push) begin
            hold_q <= sh_q;
            full_q <= 1'b1;
        end else if (do_pop) begin
            full_q <= 1'b0;
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            ferr_q <= 1'b0;
            ovf_q  <= 1'b0;
        end else begin
            ferr_q <= (ferr_q && !clr) || ferr_set;
            ovf_q  <= (ovf_q && !clr) || (push && !do_push);
        end
    end

    assign ferr = ferr_q;
    assign ovf  = ovf_q;
endmodule
